// File: rtl/vec_mem_seq_if.sv
// Single-word data-memory port used by the vector load/store sequencer.
// The sequencer is the master; the memory (or its model) is the slave.
interface vec_mem_seq_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/vec_mem_seq.sv
// MEM-stage sequencer: splits one 4-lane vector load/store into four single-word
// memory accesses and holds the pipeline until the last lane completes.
module vec_mem_seq #(
  parameter int          WIDTH     = 32,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_store,
  input  logic [31:0]      base_addr,
  input  logic [WIDTH-1:0] v1wr_in,
  input  logic [WIDTH-1:0] v2wr_in,
  input  logic [WIDTH-1:0] v3wr_in,
  input  logic [WIDTH-1:0] v4wr_in,
  vec_mem_seq_if.master    mem,
  output logic [WIDTH-1:0] v1mem_out,
  output logic [WIDTH-1:0] v2mem_out,
  output logic [WIDTH-1:0] v3mem_out,
  output logic [WIDTH-1:0] v4mem_out,
  output logic             stall,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_DONE
  } state_t;

  state_t           state;
  logic [1:0]       idx;
  logic [1:0]       idx_nxt;
  logic [31:0]      base_q;
  logic             store_q;
  logic [31:0]      next_addr;
  logic [WIDTH-1:0] wdata_q [4];
  logic [WIDTH-1:0] lane_q  [4];

  assign idx_nxt   = idx + 2'd1;
  // Address of the following lane; 32-bit wrap-around is intended.
  assign next_addr = base_q + 32'(idx_nxt) * 32'(ADDR_STEP);

  // Combinational so the hazard unit sees the hold in the same cycle start arrives.
  assign stall = (state == S_IDLE && start) || (state == S_XFER);

  // NOTE: store data is only read while a sequence is active and is always
  // loaded on start, so it needs no reset; skipping it keeps the array a plain
  // register file instead of a resettable one.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start && !reset) begin
      wdata_q[0] <= v1wr_in;
      wdata_q[1] <= v2wr_in;
      wdata_q[2] <= v3wr_in;
      wdata_q[3] <= v4wr_in;
    end
  end

  // NOTE: every register here uses <= so all state updates see the values
  // from before the clock edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      idx           <= 2'd0;
      base_q        <= '0;
      store_q       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      done          <= 1'b0;
      for (int i = 0; i < 4; i++) lane_q[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q        <= base_addr;
            store_q       <= is_store;
            idx           <= 2'd0;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= is_store;
            mem.mem_addr  <= base_addr;
            mem.mem_wdata <= v1wr_in;
            state         <= S_XFER;
          end
        end

        S_XFER: begin
          if (mem.mem_ack) begin
            if (!store_q) lane_q[idx] <= mem.mem_rdata;
            if (idx == 2'd3) begin
              mem.mem_req <= 1'b0;
              mem.mem_we  <= 1'b0;
              done        <= 1'b1;
              state       <= S_DONE;
            end else begin
              // Next lane's request is presented right after the ack: no gap.
              idx           <= idx_nxt;
              mem.mem_addr  <= next_addr;
              mem.mem_wdata <= wdata_q[idx_nxt];
            end
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

  assign v1mem_out = lane_q[0];
  assign v2mem_out = lane_q[1];
  assign v3mem_out = lane_q[2];
  assign v4mem_out = lane_q[3];

endmodule

// File: tb/tb_vec_mem_seq.sv
// Bench for vec_mem_seq: acts as the data memory (word store keyed by address)
// and predicts the access stream, stall length and lane contents of each op.
module tb_vec_mem_seq;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             is_store;
  logic [31:0]      base_addr;
  logic [WIDTH-1:0] wr [4];
  logic [WIDTH-1:0] l0, l1, l2, l3;
  logic             stall;
  logic             done;

  vec_mem_seq_if #(.WIDTH(WIDTH)) bus ();

  vec_mem_seq #(.WIDTH(WIDTH), .ADDR_STEP(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .base_addr (base_addr),
    .v1wr_in   (wr[0]),
    .v2wr_in   (wr[1]),
    .v3wr_in   (wr[2]),
    .v4wr_in   (wr[3]),
    .mem       (bus.master),
    .v1mem_out (l0),
    .v2mem_out (l1),
    .v3mem_out (l2),
    .v4mem_out (l3),
    .stall     (stall),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] exp_lane  [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lane_out(input int i);
    case (i)
      0:       return l0;
      1:       return l1;
      2:       return l2;
      default: return l3;
    endcase
  endfunction

  task automatic check_lanes(input string tag);
    for (int i = 0; i < 4; i++) check(tag, lane_out(i), exp_lane[i]);
  endtask

  // One vector op. wt >= 0: fixed wait cycles per lane; wt < 0: random 0..3.
  // poke asserts start mid-XFER and in DONE, plus a spurious ack in DONE.
  task automatic run_op(input logic [31:0] base, input bit st,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3,
                        input int wt, input bit poke);
    logic [31:0] d [4];
    logic [31:0] a;
    int stall_cnt;
    int exp_stall;
    d = '{d0, d1, d2, d3};
    check("idle_req", 32'(bus.mem_req), 0);
    start = 1'b1; is_store = st; base_addr = base; wr = d;
    #1;
    stall_cnt = stall ? 1 : 0;
    exp_stall = 1;
    tick();
    // Scramble the inputs: the DUT must work from its latched copies.
    start = 1'b0; is_store = ~st; base_addr = $urandom;
    for (int k = 0; k < 4; k++) wr[k] = $urandom;
    for (int i = 0; i < 4; i++) begin
      int w;
      w = (wt < 0) ? int'($urandom_range(3)) : wt;
      a = base + 32'(i * 4);
      for (int c = 0; c <= w; c++) begin
        #1;
        check("req", 32'(bus.mem_req), 1);
        check("addr", bus.mem_addr, a);
        check("we", 32'(bus.mem_we), 32'(st));
        if (st) check("wdata", bus.mem_wdata, d[i]);
        if (stall) stall_cnt++;
        exp_stall++;
        start = (poke && i == 1 && c == 0);
        if (c == w) begin
          bus.mem_ack = 1'b1;
          if (st) begin
            mem_model[a] = d[i];
            bus.mem_rdata = $urandom;
          end else begin
            if (!mem_model.exists(a)) mem_model[a] = $urandom;
            bus.mem_rdata = mem_model[a];
            exp_lane[i]   = mem_model[a];
          end
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
        end
        tick();
        bus.mem_ack = 1'b0;
        start       = 1'b0;
      end
    end
    #1;
    check("done", 32'(done), 1);
    check("stall_done", 32'(stall), 0);
    check("req_done", 32'(bus.mem_req), 0);
    start = poke; bus.mem_ack = poke; bus.mem_rdata = $urandom;
    tick();
    start = 1'b0; bus.mem_ack = 1'b0;
    #1;
    check("done_low", 32'(done), 0);
    check("req_idle", 32'(bus.mem_req), 0);
    check("stall_idle", 32'(stall), 0);
    check("stall_cycles", stall_cnt, exp_stall);
    check_lanes("lanes");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = '0;
    for (int k = 0; k < 4; k++) begin wr[k] = '0; exp_lane[k] = '0; end
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_req", 32'(bus.mem_req), 0);
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_done", 32'(done), 0);
    check_lanes("rst_lanes");

    // Zero-wait load from preloaded words A0..A3.
    for (int i = 0; i < 4; i++) mem_model[32'h100 + 32'(i * 4)] = 32'hA0 + 32'(i);
    run_op(32'h100, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    check("load_lane0", l0, 32'hA0);
    check("load_lane3", l3, 32'hA3);

    // Store with two wait cycles per lane, then read it back.
    run_op(32'h200, 1'b1, 1, 2, 3, 4, 2, 1'b0);
    run_op(32'h200, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    check("readback_lane1", l1, 32'd2);

    // Address wrap-around.
    run_op(32'hFFFF_FFF8, 1'b0, 0, 0, 0, 0, 1, 1'b0);

    // start during XFER/DONE ignored; a fresh op right after DONE.
    run_op(32'h400, 1'b0, 0, 0, 0, 0, -1, 1'b1);
    run_op(32'h500, 1'b1, 9, 8, 7, 6, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      logic [31:0] b;
      b = (n % 3 == 0) ? 32'h600 : {$urandom_range(255), 2'b00};
      run_op(b, 1'($urandom_range(1)), $urandom, $urandom, $urandom, $urandom,
             -1, 1'($urandom_range(1)));
    end

    // Spurious ack while IDLE.
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_ack = 1'b0;
    #1;
    check("spur_req", 32'(bus.mem_req), 0);
    check("spur_done", 32'(done), 0);
    check_lanes("spur_lanes");

    // reset, start and ack together: reset wins.
    reset = 1'b1; start = 1'b1; base_addr = 32'h700; bus.mem_ack = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; bus.mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) exp_lane[k] = '0;
    #1;
    check("rst_start_req", 32'(bus.mem_req), 0);
    check("rst_start_stall", 32'(stall), 0);
    check_lanes("rst_start_lanes");
    tick();
    check("rst_start_req2", 32'(bus.mem_req), 0);

    // Abort mid-XFER after the lane-1 ack.
    run_op(32'h800, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    start = 1'b1; is_store = 1'b0; base_addr = 32'h900;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("abort_addr", bus.mem_addr, 32'h900 + 32'(i * 4));
      bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
      tick();
      bus.mem_ack = 1'b0;
    end
    #1;
    reset = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
    tick();
    reset = 1'b0; bus.mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) exp_lane[k] = '0;
    #1;
    check("abort_req", 32'(bus.mem_req), 0);
    check("abort_stall", 32'(stall), 0);
    check_lanes("abort_lanes");
    for (int c = 0; c < 4; c++) begin
      check("abort_done", 32'(done), 0);
      tick();
    end
    #1;
    run_op(32'hA00, 1'b0, 0, 0, 0, 0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_mem_seq.md
Name: vec_mem_seq

Overview:
- Sequences one 4-lane vector load or store through the single-word data-memory port, one lane per access.
- Presents the four gathered lanes as v1mem..v4mem for the MEM/WB pipeline register.
- Holds the pipeline with `stall` while lane accesses are in flight.
- Sits in the MEM stage, between the EX/MEM register outputs and the data memory.

Parameters:
- WIDTH, 32, lane and memory data width.
- ADDR_STEP, 4, byte address increment between consecutive lanes.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  vector memory op present in MEM stage.
- is_store  in  1  1 = store, 0 = load; sampled with start.
- base_addr  in  32  lane-0 byte address; sampled with start.
- v1wr_in..v4wr_in  in  WIDTH each  store data for lanes 0..3; sampled with start.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable, valid with mem_req.
- mem_addr  out  32  access address.
- mem_wdata  out  WIDTH  store data.
- mem_rdata  in  WIDTH  load data, valid with mem_ack.
- mem_ack  in  1  access complete.
- v1mem_out..v4mem_out  out  WIDTH each  loaded lanes 0..3.
- stall  out  1  freeze pipeline stages upstream of and including MEM.
- done  out  1  single-cycle completion pulse.

Behaviour:
- State machine: IDLE, XFER, DONE. Internal registers: lane index idx[1:0], latched base, is_store, and the four store-data words.
- IDLE:
  - start=1 latches base_addr, is_store and v1wr..v4wr; clears idx to 0; next state XFER.
  - start=0 stays in IDLE.
- XFER:
  - mem_req=1.
  - mem_addr = latched base + idx*ADDR_STEP, modulo 2^32 (wrap-around is allowed, no error).
  - mem_we = latched is_store.
  - mem_wdata = latched store word[idx].
  - Request stays high, with address, data and we stable, until mem_ack=1.
- On mem_ack in XFER:
  - If load, mem_rdata is written into lane idx at that clock edge.
  - If idx==3, next state is DONE; otherwise idx increments and the state stays XFER. The next lane's request follows in the next cycle with no idle gap.
- mem_ack in the same cycle as the first asserted mem_req is legal (zero-wait memory).
- mem_ack outside XFER is ignored.
- DONE: done=1 and stall=0 for one cycle; next state IDLE.
- stall = (state==IDLE && start) || state==XFER. stall is combinational, so it rises in the same cycle start is presented.
- start is accepted only in IDLE; start in XFER or DONE is ignored. With stall low in DONE, the next instruction reaches MEM only after the return to IDLE.
- Lane outputs are registered. They hold their last loaded values until overwritten by a later load. Stores never modify them. A load updates all four lanes in lane order.
- Latency with zero-wait memory: start at cycle T, XFER T+1..T+4, done at T+5, stall high T..T+4 (5 cycles). Each wait cycle of memory adds one cycle.
- Reset values: state IDLE, idx 0, all lanes 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, stall 0, done 0.
- Reset asserted mid-XFER aborts the operation at that edge: no further lane writes, and mem_req is low in the following cycle. Lanes already loaded are cleared to 0.
- reset has priority over start and mem_ack in the same cycle.

Test Plan:
- Load, zero-wait: base=0x100, memory returns 0xA0..0xA3 on consecutive acks. Required: mem_addr 0x100, 0x104, 0x108, 0x10C; lanes = A0, A1, A2, A3; stall high 5 cycles; done at T+5.
- Store with 2 wait cycles per lane: base=0x200, v1..v4wr=1,2,3,4. Required: mem_we=1 throughout; each address/data pair held 3 cycles; 12 XFER cycles; lanes unchanged.
- Address wrap: base=0xFFFFFFF8, load. Required: addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- start pulsed during XFER and in DONE: ignored, with no extra accesses; a new start one cycle after DONE begins a fresh sequence.
- Reset after the lane-1 ack: the next cycle shows mem_req=0, state IDLE, all lanes 0, stall=0, done never pulses.
- Spurious mem_ack while IDLE, with reset and start together: no lane change, no state transition.
